// File: rtl/char_cell_scanner_pkg.sv
// Shared types and constants for the character-cell scanner family.
//   COLOUR_W / COORD_W : pixel colour and screen coordinate widths.
//   CNT_W              : in-cell counter width (cells are at most 16x16).
//   DEF_CELL_W/H       : default cell geometry.
//   state_e            : scanner FSM states.
//   cell_coord()       : origin + in-cell offset, modulo 2^COORD_W.
package char_pkg;

  localparam int COLOUR_W   = 6;
  localparam int COORD_W    = 8;
  localparam int CNT_W      = 4;
  localparam int DEF_CELL_W = 10;
  localparam int DEF_CELL_H = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Screen coordinates wrap at 256; there is deliberately no clipping.
  function automatic logic [COORD_W-1:0] cell_coord(input logic [COORD_W-1:0] origin,
                                                    input logic [CNT_W-1:0]   offset);
    return origin + COORD_W'(offset);
  endfunction

endpackage

// File: rtl/char_cell_scanner_if.sv
// Glyph-decoder and plotter bus of the character-cell scanner.
//   flush_x/flush_y           : absolute pixel presented to the glyph decoder.
//   glyph_colour/glyph_enable : combinational decoder answer for that pixel.
//   plot/plot_x/plot_y/plot_colour : pixel write towards the plotter.
//   plot_ready                : plotter accepts the write when plot && plot_ready.
// master = scanner side, slave = decoder/plotter side.
interface char_cell_scanner_if;
  import char_pkg::*;

  logic [COORD_W-1:0]  flush_x;
  logic [COORD_W-1:0]  flush_y;
  logic [COLOUR_W-1:0] glyph_colour;
  logic                glyph_enable;
  logic                plot;
  logic [COORD_W-1:0]  plot_x;
  logic [COORD_W-1:0]  plot_y;
  logic [COLOUR_W-1:0] plot_colour;
  logic                plot_ready;

  modport master (
    output flush_x, flush_y, plot, plot_x, plot_y, plot_colour,
    input  glyph_colour, glyph_enable, plot_ready
  );

  modport slave (
    input  flush_x, flush_y, plot, plot_x, plot_y, plot_colour,
    output glyph_colour, glyph_enable, plot_ready
  );

endinterface

// File: rtl/char_cell_scanner_raster.sv
// cell_raster_counter: raster position (cx, cy) inside a CELL_W x CELL_H cell.
//   clk, rst    : clock, asynchronous active-high reset.
//   clear_i     : return to (0,0); wins over advance_i.
//   advance_i   : step one pixel in raster order (x fastest).
//   cx_o, cy_o  : current in-cell position.
//   last_o      : current position is the final pixel of the cell.
module cell_raster_counter
  import char_pkg::*;
#(
  parameter int unsigned CELL_W = DEF_CELL_W,
  parameter int unsigned CELL_H = DEF_CELL_H
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [CNT_W-1:0] cx_o,
  output logic [CNT_W-1:0] cy_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] CX_MAX = CNT_W'(CELL_W - 1);
  localparam logic [CNT_W-1:0] CY_MAX = CNT_W'(CELL_H - 1);

  logic [CNT_W-1:0] cx_q, cx_d;
  logic [CNT_W-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (advance_i) begin
      if (cx_q == CX_MAX) begin
        cx_d = '0;
        cy_d = (cy_q == CY_MAX) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == CX_MAX) && (cy_q == CY_MAX);

endmodule

// File: rtl/char_cell_scanner.sv
// char_cell_scanner: scans one character cell through a combinational glyph
// decoder and emits the resulting pixel writes with ready back-pressure.
//   clk, reset        : clock, asynchronous active-high reset.
//   start             : draw request, only honoured in IDLE.
//   char_x, char_y    : cell origin, latched when start is accepted.
//   gif (master)      : flush_* to the decoder, glyph_* back, plot_* to plotter.
//   busy              : accepted start through the done cycle, inclusive.
//   done              : one-cycle pulse once the last write has gone out.
module char_cell_scanner
  import char_pkg::*;
#(
  parameter int unsigned         CELL_W    = DEF_CELL_W,
  parameter int unsigned         CELL_H    = DEF_CELL_H,
  parameter bit                  DRAW_BG   = 1'b0,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [COORD_W-1:0]  char_x,
  input  logic [COORD_W-1:0]  char_y,
  char_cell_scanner_if.master gif,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  org_x_q, org_x_d, org_y_q, org_y_d;
  logic                plot_q, plot_d;
  logic [COORD_W-1:0]  plot_x_q, plot_x_d, plot_y_q, plot_y_d;
  logic [COLOUR_W-1:0] plot_colour_q, plot_colour_d;
  logic [COORD_W-1:0]  flush_x, flush_y;
  logic [CNT_W-1:0]    cx, cy;
  logic                last, clear, advance;

  cell_raster_counter #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H)
  ) u_raster (
    .clk       (clk),
    .rst       (reset),
    .clear_i   (clear),
    .advance_i (advance),
    .cx_o      (cx),
    .cy_o      (cy),
    .last_o    (last)
  );

  always_comb begin
    state_d       = state_q;
    org_x_d       = org_x_q;
    org_y_d       = org_y_q;
    plot_d        = plot_q;
    plot_x_d      = plot_x_q;
    plot_y_d      = plot_y_q;
    plot_colour_d = plot_colour_q;
    flush_x       = '0;
    flush_y       = '0;
    clear         = 1'b0;
    advance       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          org_x_d = char_x;
          org_y_d = char_y;
          clear   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        flush_x = cell_coord(org_x_q, cx);
        flush_y = cell_coord(org_y_q, cy);
        // Only a pending, unaccepted write stalls; an empty slot always refills.
        if (!(plot_q && !gif.plot_ready)) begin
          advance       = 1'b1;
          plot_d        = gif.glyph_enable | DRAW_BG;
          plot_x_d      = flush_x;
          plot_y_d      = flush_y;
          plot_colour_d = gif.glyph_enable ? gif.glyph_colour : BG_COLOUR;
          if (last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The final pixel's write is still in the output slot here.
        if (!plot_q || gif.plot_ready) begin
          plot_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- output pipeline stage: decoder answer -> registered pixel write ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      org_x_q       <= '0;
      org_y_q       <= '0;
      plot_q        <= 1'b0;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
    end else begin
      state_q       <= state_d;
      org_x_q       <= org_x_d;
      org_y_q       <= org_y_d;
      plot_q        <= plot_d;
      plot_x_q      <= plot_x_d;
      plot_y_q      <= plot_y_d;
      plot_colour_q <= plot_colour_d;
    end
  end

  assign gif.flush_x     = flush_x;
  assign gif.flush_y     = flush_y;
  assign gif.plot        = plot_q;
  assign gif.plot_x      = plot_x_q;
  assign gif.plot_y      = plot_y_q;
  assign gif.plot_colour = plot_colour_q;
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_char_cell_scanner.sv
module tb_char_cell_scanner;
  import char_pkg::*;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } wr_t;

  localparam logic [5:0] FG  = 6'h3F;
  localparam logic [5:0] BG1 = 6'h03;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [7:0] char_x, char_y;
  logic busy0, done0, busy1, done1;
  logic rdy0, rdy1;
  logic [7:0] org0_x, org0_y, org1_x, org1_y;

  int checks, failures;
  int run0, run1, bg1, fg1, bp_hits;
  bit bp_arm, have_fg1;
  wr_t first0, prev0, last0, first1, last1, first_fg1;
  wr_t q0[$];
  wr_t q1[$];

  always #5 clk = ~clk;

  // Reference "Y"-shaped glyph, 20 lit pixels, offsets relative to the cell origin.
  function automatic logic glyph_hit(input logic [7:0] rx, input logic [7:0] ry);
    case (ry)
      8'd0:                    return rx == 8'd2 || rx == 8'd3 || rx == 8'd7 || rx == 8'd8;
      8'd1:                    return rx == 8'd3 || rx == 8'd7;
      8'd2:                    return rx == 8'd4 || rx == 8'd6;
      8'd3, 8'd4:              return rx == 8'd5;
      8'd5, 8'd6, 8'd7, 8'd8, 8'd9: return rx == 8'd4 || rx == 8'd5;
      default:                 return 1'b0;
    endcase
  endfunction

  char_cell_scanner_if if0 ();
  char_cell_scanner_if if1 ();

  assign if0.plot_ready   = rdy0;
  assign if0.glyph_enable = glyph_hit(if0.flush_x - org0_x, if0.flush_y - org0_y);
  assign if0.glyph_colour = if0.glyph_enable ? FG : 6'h15;
  assign if1.plot_ready   = rdy1;
  assign if1.glyph_enable = glyph_hit(if1.flush_x - org1_x, if1.flush_y - org1_y);
  assign if1.glyph_colour = if1.glyph_enable ? FG : 6'h15;

  char_cell_scanner #(
    .CELL_W(10), .CELL_H(10), .DRAW_BG(1'b0), .BG_COLOUR(6'b000000)
  ) u_dut0 (
    .clk(clk), .reset(rst), .start(start0), .char_x(char_x), .char_y(char_y),
    .gif(if0), .busy(busy0), .done(done0)
  );

  char_cell_scanner #(
    .CELL_W(10), .CELL_H(10), .DRAW_BG(1'b1), .BG_COLOUR(BG1)
  ) u_dut1 (
    .clk(clk), .reset(rst), .start(start1), .char_x(char_x), .char_y(char_y),
    .gif(if1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected writes of one cell in raster order.
  task automatic push_exp(input int inst, input logic [7:0] ox, input logic [7:0] oy);
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        logic hit;
        wr_t w;
        hit = glyph_hit(8'(c), 8'(r));
        w.x = ox + 8'(c);
        w.y = oy + 8'(r);
        w.c = hit ? FG : BG1;
        if (inst == 0) begin
          if (hit) q0.push_back(w);
        end else begin
          q1.push_back(w);
        end
      end
    end
  endtask

  // Scoreboard monitor: a write is taken whenever plot && plot_ready.
  initial begin
    wr_t w, e;
    forever begin
      @(negedge clk);
      if (!rst && if0.plot && rdy0) begin
        w = '{if0.plot_x, if0.plot_y, if0.plot_colour};
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb0_extra actual=%0h required=none", w);
        end else begin
          e = q0.pop_front();
          check("sb0_write", 64'(w), 64'(e));
        end
        if (run0 == 0) first0 = w;
        prev0 = last0;
        last0 = w;
        run0++;
      end
      if (!rst && if1.plot && rdy1) begin
        w = '{if1.plot_x, if1.plot_y, if1.plot_colour};
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb1_extra actual=%0h required=none", w);
        end else begin
          e = q1.pop_front();
          check("sb1_write", 64'(w), 64'(e));
        end
        if (run1 == 0) first1 = w;
        last1 = w;
        if (w.c == FG) begin
          fg1++;
          if (!have_fg1) begin first_fg1 = w; have_fg1 = 1'b1; end
        end else begin
          bg1++;
        end
        run1++;
      end
    end
  end

  // Ready driver for the DRAW_BG=0 instance: optional 5-cycle stall on its 3rd write.
  initial begin
    rdy0 = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_arm && if0.plot && run0 == 2) begin
        bp_arm = 1'b0;
        bp_hits++;
        rdy0 = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check("bp_hold", 64'({if0.plot, if0.plot_x, if0.plot_y, if0.plot_colour}),
                64'({1'b1, 8'd27, 8'd30, FG}));
        end
        rdy0 = 1'b1;
      end
    end
  end

  task automatic run_cell(input int inst, input logic [7:0] x, input logic [7:0] y,
                          input bit hold, output int cyc);
    char_x = x;
    char_y = y;
    push_exp(inst, x, y);
    if (inst == 0) begin
      org0_x = x; org0_y = y; run0 = 0; start0 = 1'b1;
    end else begin
      org1_x = x; org1_y = y; run1 = 0; bg1 = 0; fg1 = 0; have_fg1 = 1'b0; start1 = 1'b1;
    end
    @(posedge clk); #1;
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    char_x = 8'hAA;
    char_y = 8'h55;
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_start", 64'(inst == 0 ? busy0 : busy1), 64'd1);
      if ((inst == 0 ? done0 : done1) == 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("busy_in_done", 64'(inst == 0 ? busy0 : busy1), 64'd1);
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check("idle_after_done", 64'(inst == 0 ? {busy0, done0} : {busy1, done1}), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(inst == 0 ? q0.size() : q1.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    bit got, seen;
    checks = 0; failures = 0;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; char_x = '0; char_y = '0;
    org0_x = '0; org0_y = '0; org1_x = '0; org1_y = '0;
    rdy1 = 1'b1; bp_arm = 1'b0; bp_hits = 0;
    run0 = 0; run1 = 0; bg1 = 0; fg1 = 0; have_fg1 = 1'b0;
    @(posedge clk); #1;
    check("rst_ctrl", 64'({busy0, done0, if0.plot, busy1, done1, if1.plot}), 64'd0);
    check("rst_data", 64'({if0.plot_x, if0.plot_y, if0.plot_colour, if0.flush_x, if0.flush_y}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Glyph only, origin (20,30)
    run_cell(0, 8'd20, 8'd30, 1'b0, cyc);
    check("t1_cycles", 64'(cyc), 64'd102);
    check("t1_count", 64'(run0), 64'd20);
    check("t1_first", 64'(first0), 64'({8'd22, 8'd30, FG}));
    check("t1_prev_last", 64'(prev0), 64'({8'd24, 8'd39, FG}));
    check("t1_last", 64'(last0), 64'({8'd25, 8'd39, FG}));

    // Background drawn
    run_cell(1, 8'd20, 8'd30, 1'b0, cyc);
    check("t2_cycles", 64'(cyc), 64'd102);
    check("t2_count", 64'(run1), 64'd100);
    check("t2_bg", 64'(bg1), 64'd80);
    check("t2_fg", 64'(fg1), 64'd20);
    check("t2_first", 64'(first1), 64'({8'd20, 8'd30, BG1}));
    check("t2_last", 64'(last1), 64'({8'd29, 8'd39, BG1}));

    // Back-pressure on the 3rd write
    bp_arm = 1'b1;
    run_cell(0, 8'd20, 8'd30, 1'b0, cyc);
    check("t3_cycles", 64'(cyc), 64'd107);
    check("t3_count", 64'(run0), 64'd20);
    check("t3_stall_seen", 64'(bp_hits), 64'd1);

    // Coordinate wrap
    run_cell(1, 8'd250, 8'd250, 1'b0, cyc);
    check("t4_cycles", 64'(cyc), 64'd102);
    check("t4_count", 64'(run1), 64'd100);
    check("t4_first_glyph", 64'(first_fg1), 64'({8'd252, 8'd250, FG}));
    check("t4_last", 64'(last1), 64'({8'd3, 8'd3, BG1}));

    // start held high into DONE
    run_cell(0, 8'd20, 8'd30, 1'b1, cyc);
    check("t5_cycles", 64'(cyc), 64'd102);
    check("t5_count", 64'(run0), 64'd20);

    // Reset in the middle of a scan
    push_exp(1, 8'd40, 8'd50);
    org1_x = 8'd40; org1_y = 8'd50; char_x = 8'd40; char_y = 8'd50;
    run1 = 0; bg1 = 0; fg1 = 0; have_fg1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (run1 >= 37) begin got = 1'b1; break; end
    end
    check("t6_reached_37", 64'(got), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_async_ctrl", 64'({busy1, done1, if1.plot}), 64'd0);
    check("t6_async_data", 64'({if1.plot_x, if1.plot_y, if1.plot_colour, if1.flush_x, if1.flush_y}), 64'd0);
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done1 || busy1) seen = 1'b1;
    end
    @(posedge clk); #1;
    check("t6_no_done", 64'(seen), 64'd0);
    run_cell(1, 8'd0, 8'd0, 1'b0, cyc);
    check("t6_cycles", 64'(cyc), 64'd102);
    check("t6_count", 64'(run1), 64'd100);
    check("t6_first", 64'(first1), 64'({8'd0, 8'd0, BG1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
